// File: rtl/huffman_encoder.sv
// huffman_encoder: serialises one JPEG (run, size, amplitude) symbol as Huffman code bits, then amplitude bits.
// Define HUFF_BIT_COUNT_EN to add bit_count, a 32-bit wrapping count of transferred bits.
module huffman_encoder #(
    parameter int CODE_W = 16,
    parameter int AMP_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ac_dc_flag,
    input  logic [3:0]        r_value,
    input  logic [3:0]        s_value,
    input  logic [AMP_W-1:0]  amplitude,
    input  logic              sym_valid,
    output logic              sym_ready,
    output logic              tbl_ac_dc,
    output logic [3:0]        tbl_r,
    output logic [3:0]        tbl_s,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic [4:0]        tbl_len,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef HUFF_BIT_COUNT_EN
    output logic [31:0]       bit_count,
`endif
    output logic              busy,
    output logic              err
);
    // state  | meaning
    // IDLE   | waiting for a symbol, sym_ready high
    // LOOKUP | registered symbol on tbl_*, capture code and length
    // CODE   | shifting out Huffman code bits MSB-first
    // AMP    | shifting out the low s amplitude bits MSB-first
    typedef enum logic [1:0] {IDLE, LOOKUP, CODE, AMP} state_t;

    localparam logic [5:0] CODE_W_L = 6'(CODE_W);
    localparam logic [4:0] AMP_W_L  = 5'(AMP_W);

    state_t              state;
    state_t              state_nxt;
    logic                flag_q;
    logic [3:0]          r_q;
    logic [3:0]          s_q;
    logic [AMP_W-1:0]    amp_q;
    logic [CODE_W-1:0]   code_q;
    logic [4:0]          cnt_q;
    logic                err_q;
    logic                bad_sym;
    logic                last;

    assign bad_sym = (tbl_len == 5'd0) || ({1'b0, tbl_len} > CODE_W_L) ||
                     (flag_q ? (s_q > 4'd11) : (s_q > 4'd10));
    assign last    = (cnt_q == 5'd0);

    assign tbl_ac_dc = flag_q;
    assign tbl_r     = r_q;
    assign tbl_s     = s_q;
    assign busy      = (state != IDLE);
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sym_ready = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        case (state)
            IDLE: begin
                sym_ready = 1'b1;
                if (sym_valid)
                    state_nxt = LOOKUP;
            end
            LOOKUP: state_nxt = bad_sym ? IDLE : CODE;
            CODE: begin
                out_valid = 1'b1;
                out_bit   = code_q[CODE_W-1];
                if (out_ready && last)
                    state_nxt = (s_q != 4'd0) ? AMP : IDLE;
            end
            AMP: begin
                out_valid = 1'b1;
                out_bit   = amp_q[AMP_W-1];
                if (out_ready && last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Code and amplitude are held left-aligned so the output bit is always the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
            r_q    <= '0;
            s_q    <= '0;
            amp_q  <= '0;
            code_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sym_valid) begin
                        flag_q <= ac_dc_flag;
                        r_q    <= ac_dc_flag ? 4'd0 : r_value;
                        s_q    <= s_value;
                        amp_q  <= amplitude << (AMP_W_L - {1'b0, s_value});
                    end
                end
                LOOKUP: begin
                    code_q <= tbl_code << (CODE_W_L - {1'b0, tbl_len});
                    cnt_q  <= tbl_len - 5'd1;
                    if (bad_sym)
                        err_q <= 1'b1;
                end
                CODE: begin
                    if (out_ready) begin
                        if (last) begin
                            cnt_q <= {1'b0, s_q} - 5'd1;
                        end else begin
                            cnt_q  <= cnt_q - 5'd1;
                            code_q <= code_q << 1;
                        end
                    end
                end
                AMP: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q - 5'd1;
                        amp_q <= amp_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HUFF_BIT_COUNT_EN
    logic [31:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            bit_cnt <= '0;
        else if (out_valid && out_ready)
            bit_cnt <= bit_cnt + 32'd1;
    end

    assign bit_count = bit_cnt;
`endif

endmodule
